pll_lock_sequencer: RTL

Reset/lock controller sitting on the far side of the board PLL: drives the PLL `reset` input, watches its asynchronous `lock` output, and releases the design's system reset only after lock has been stable for a programmed time. Runs on the raw 27 MHz oscillator clock that also feeds the PLL. Retries on lock timeout and latches a fault after too many failures. Re-sequences on lock loss or on software request.

---
 rtl/clk_rst_pkg.sv | 8 +
 rtl/cdc_sync2.sv | 19 +
 rtl/pll_lock_sequencer.sv | 78 +++++++
 3 files changed

// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: PLL sequencer state type and 27 MHz board default cycle counts
package clk_rst_pkg;
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT} pll_seq_state_t;
  localparam int DEF_PLL_RESET_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 27000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 256;
  localparam int DEF_MAX_RETRIES         = 7;
endpackage

// File: rtl/cdc_sync2.sv
// cdc_sync2: W-bit two-flop synchronizer (clk, async active-high rst, d in, q synced out)
module cdc_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock sequencer (clkin, async reset, lock, req_reset -> pll_reset, sys_reset, ready, fault, retry_cnt)
module pll_lock_sequencer
  import clk_rst_pkg::*;
#(
  parameter int PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock,
  input  logic       req_reset,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt
);
  localparam int MAX_AB = PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES ? PLL_RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_C  = MAX_AB > LOCK_STABLE_CYCLES ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;
  localparam logic [CW-1:0] RST_END  = CW'(PLL_RESET_CYCLES - 1);
  localparam logic [CW-1:0] TOUT_END = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STAB_END = CW'(LOCK_STABLE_CYCLES - 1);
  pll_seq_state_t state, state_n;
  logic [CW-1:0]  cnt;
  logic [3:0]     retry_n;
  logic           lock_s;
  cdc_sync2 #(.W(1)) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (lock),
    .q   (lock_s)
  );
  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    if (req_reset) begin
      state_n = PLL_RST;
      retry_n = '0;
    end else begin
      case (state)
        PLL_RST:   state_n = cnt == RST_END ? WAIT_LOCK : PLL_RST;
        WAIT_LOCK: if (lock_s) state_n = STABLE;
                   else if (cnt == TOUT_END) begin
                     state_n = retry_cnt == 4'(MAX_RETRIES) ? FAULT : PLL_RST;
                     retry_n = retry_cnt == 4'(MAX_RETRIES) ? retry_cnt : retry_cnt + 4'd1;
                   end
        STABLE:    state_n = !lock_s ? WAIT_LOCK : cnt == STAB_END ? RUN : STABLE;
        RUN:       if (!lock_s) begin
                     state_n = PLL_RST;
                     retry_n = '0;
                   end
        default:   state_n = FAULT;
      endcase
    end
  end
  // A req_reset re-entry into PLL_RST counts as a state entry, so cnt clears even if state is unchanged.
  always_ff @(posedge clkin or posedge reset)
    if (reset) begin
      state     <= PLL_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_reset <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= (req_reset || state_n != state) ? '0 : cnt + 1'b1;
      retry_cnt <= retry_n;
      pll_reset <= state_n == PLL_RST || state_n == FAULT;
      sys_reset <= state_n != RUN;
      ready     <= state_n == RUN;
      fault     <= state_n == FAULT;
    end
endmodule
